// File: rtl/nand_sched_pkg.sv
// Shared encodings for the NAND command scheduler: ops, status codes, FSM states
// and the queued command entry.
package nand_sched_pkg;

   localparam logic [1:0] OP_WRITE   = 2'd0;
   localparam logic [1:0] OP_READ    = 2'd1;
   localparam logic [1:0] OP_ERASE   = 2'd2;
   localparam logic [1:0] OP_ILLEGAL = 2'd3;

   localparam logic [1:0] ST_OK      = 2'd0;
   localparam logic [1:0] ST_TIMEOUT = 2'd1;
   localparam logic [1:0] ST_NORESP  = 2'd2;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWait,
      StDone,
      StAbortNr,
      StAbortTo,
      StGap
   } state_e;

   typedef struct packed {
      logic        src;
      logic [1:0]  op;
      logic [23:0] row;
   } entry_t;

   localparam int unsigned ENTRY_W = 27;

endpackage

// File: rtl/nand_cmd_fifo.sv
// Synchronous command FIFO with first-word-fall-through head; flush empties it and
// wins over a same-cycle push.
module nand_cmd_fifo
   import nand_sched_pkg::*;
#(
   parameter int unsigned Depth = 4,
   parameter int unsigned Width = ENTRY_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [Width-1:0]         wdata,
   input  logic                     pop,
   input  logic                     flush,
   output logic [Width-1:0]         head,
   output logic [$clog2(Depth):0]   count
);

   localparam int unsigned AW = $clog2(Depth);
   localparam logic [AW:0] Full = (AW + 1)'(Depth);

   logic [Width-1:0] mem [Depth];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             push_ok, pop_ok;

   assign push_ok = push && (count_q != Full);
   assign pop_ok  = pop && (count_q != '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok && !flush) mem[wr_ptr_q] <= wdata;
   end

   assign head  = mem[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/nand_cmd_scheduler.sv
// Round-robin two-requester command scheduler in front of the NAND controller:
// queues commands, issues one at a time with a watchdog, reports completion status.
module nand_cmd_scheduler
   import nand_sched_pkg::*;
#(
   parameter int unsigned QUEUE_DEPTH    = 4,
   parameter int unsigned TIMEOUT_CYCLES = 2400000,
   parameter int unsigned GAP_CYCLES     = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           req0_valid,
   output logic                           req0_ready,
   input  logic [1:0]                     req0_op,
   input  logic [23:0]                    req0_row,
   input  logic                           req1_valid,
   output logic                           req1_ready,
   input  logic [1:0]                     req1_op,
   input  logic [23:0]                    req1_row,
   input  logic                           flush,
   output logic                           en_write_page,
   output logic                           en_read,
   output logic                           en_erase_page,
   output logic [23:0]                    write_addr_row,
   output logic [23:0]                    read_addr_row,
   output logic [23:0]                    erase_addr_row,
   input  logic                           end_write_page,
   input  logic                           end_read,
   input  logic                           end_erase_page,
   input  logic                           nandflash_busy_Noresponse,
   output logic                           cmp_valid,
   output logic                           cmp_src,
   output logic [1:0]                     cmp_op,
   output logic [1:0]                     cmp_status,
   output logic                           illegal_op,
   output logic [$clog2(QUEUE_DEPTH):0]   q_count,
   output logic                           busy
);

   localparam int unsigned CntW = $clog2(QUEUE_DEPTH) + 1;
   localparam int unsigned WdW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [CntW-1:0] QFull   = CntW'(QUEUE_DEPTH);
   localparam logic [WdW-1:0]  WdLast  = WdW'(TIMEOUT_CYCLES - 1);
   localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

   // Arbitration: rr_q set means req1 wins a tie.
   logic   rr_q, illegal_q;
   logic   space, grant0, grant1, accept, push, pop;
   entry_t acc_entry, cmd_q, cmd_d;
   logic [ENTRY_W-1:0] head;

   assign space      = (q_count < QFull) && !flush;
   assign grant0     = req0_valid && (!req1_valid || !rr_q);
   assign grant1     = req1_valid && (!req0_valid || rr_q);
   assign req0_ready = grant0 && space;
   assign req1_ready = grant1 && space;
   assign accept     = req0_ready || req1_ready;

   always_comb begin
      acc_entry.src = req1_ready;
      acc_entry.op  = req1_ready ? req1_op : req0_op;
      acc_entry.row = req1_ready ? req1_row : req0_row;
   end

   assign push = accept && (acc_entry.op != OP_ILLEGAL);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_q      <= 1'b0;
         illegal_q <= 1'b0;
      end else if (accept) begin
         rr_q <= !acc_entry.src;
         if (acc_entry.op == OP_ILLEGAL) illegal_q <= 1'b1;
      end
   end

   assign illegal_op = illegal_q;

   nand_cmd_fifo #(
      .Depth (QUEUE_DEPTH),
      .Width (ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (acc_entry),
      .pop   (pop),
      .flush (flush),
      .head  (head),
      .count (q_count)
   );

   state_e          state_q, state_d;
   logic [WdW-1:0]  wd_q, wd_d;
   logic [GapW-1:0] gap_q, gap_d;
   logic [2:0]      en_q, en_d;
   logic            end_match;

   always_comb begin
      end_match = 1'b0;
      case (cmd_q.op)
         OP_WRITE: end_match = end_write_page;
         OP_READ:  end_match = end_read;
         OP_ERASE: end_match = end_erase_page;
         default:  end_match = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      wd_d    = wd_q;
      gap_d   = gap_q;
      pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (q_count != '0 && !flush) begin
               pop     = 1'b1;
               cmd_d   = head;
               state_d = StIssue;
            end
         end
         StIssue: begin
            wd_d    = '0;
            state_d = StWait;
         end
         StWait: begin
            wd_d = wd_q + 1'b1;
            if (end_match)                      state_d = StDone;
            else if (nandflash_busy_Noresponse) state_d = StAbortNr;
            else if (wd_q == WdLast)            state_d = StAbortTo;
         end
         StDone, StAbortNr, StAbortTo: begin
            gap_d   = '0;
            state_d = StGap;
         end
         StGap: begin
            gap_d = gap_q + 1'b1;
            if (gap_q == GapLast) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Enables are registered straight from next-state so they never glitch.
   always_comb begin
      en_d = 3'b000;
      if (state_d == StWait) begin
         case (cmd_d.op)
            OP_WRITE: en_d = 3'b001;
            OP_READ:  en_d = 3'b010;
            OP_ERASE: en_d = 3'b100;
            default:  en_d = 3'b000;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         cmd_q   <= '0;
         wd_q    <= '0;
         gap_q   <= '0;
         en_q    <= 3'b000;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         wd_q    <= wd_d;
         gap_q   <= gap_d;
         en_q    <= en_d;
      end
   end

   logic active;
   assign active = state_q inside {StIssue, StWait, StDone, StAbortNr, StAbortTo};

   assign en_write_page  = en_q[0];
   assign en_read        = en_q[1];
   assign en_erase_page  = en_q[2];
   assign write_addr_row = (active && cmd_q.op == OP_WRITE) ? cmd_q.row : '0;
   assign read_addr_row  = (active && cmd_q.op == OP_READ)  ? cmd_q.row : '0;
   assign erase_addr_row = (active && cmd_q.op == OP_ERASE) ? cmd_q.row : '0;

   assign cmp_valid = state_q inside {StDone, StAbortNr, StAbortTo};
   assign cmp_src   = cmp_valid && cmd_q.src;
   assign cmp_op    = cmp_valid ? cmd_q.op : 2'd0;

   always_comb begin
      cmp_status = ST_OK;
      if (state_q == StAbortNr)      cmp_status = ST_NORESP;
      else if (state_q == StAbortTo) cmp_status = ST_TIMEOUT;
   end

   assign busy = (state_q != StIdle) || (q_count != '0);

endmodule

// File: tb/tb_nand_cmd_scheduler.sv
// Directed bench for nand_cmd_scheduler: accept latency, round-robin, flush, timeout,
// no-response, illegal op and asynchronous reset mid-operation.
module tb_nand_cmd_scheduler;

   localparam logic [1:0] W = 2'd0, R = 2'd1, E = 2'd2, ILL = 2'd3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req0_valid = 0, req1_valid = 0, flush = 0;
   logic        req0_ready, req1_ready;
   logic [1:0]  req0_op = 0, req1_op = 0;
   logic [23:0] req0_row = 0, req1_row = 0;
   logic        en_write_page, en_read, en_erase_page;
   logic [23:0] write_addr_row, read_addr_row, erase_addr_row;
   logic        end_write_page = 0, end_read = 0, end_erase_page = 0, noresp = 0;
   logic        cmp_valid, cmp_src, illegal_op, busy;
   logic [1:0]  cmp_op, cmp_status;
   logic [2:0]  q_count;
   logic [2:0]  en_v;

   int vectors = 0, miscompares = 0;
   int onehot_bad = 0, low_run = 0, min_gap = 1000;
   bit seen_en = 0;
   logic [4:0] cmp_q[$];
   logic       acc_q[$];

   always #5 clk = ~clk;

   nand_cmd_scheduler #(
      .QUEUE_DEPTH    (4),
      .TIMEOUT_CYCLES (100),
      .GAP_CYCLES     (4)
   ) dut (
      .clk                       (clk),
      .rst                       (rst),
      .req0_valid                (req0_valid),
      .req0_ready                (req0_ready),
      .req0_op                   (req0_op),
      .req0_row                  (req0_row),
      .req1_valid                (req1_valid),
      .req1_ready                (req1_ready),
      .req1_op                   (req1_op),
      .req1_row                  (req1_row),
      .flush                     (flush),
      .en_write_page             (en_write_page),
      .en_read                   (en_read),
      .en_erase_page             (en_erase_page),
      .write_addr_row            (write_addr_row),
      .read_addr_row             (read_addr_row),
      .erase_addr_row            (erase_addr_row),
      .end_write_page            (end_write_page),
      .end_read                  (end_read),
      .end_erase_page            (end_erase_page),
      .nandflash_busy_Noresponse (noresp),
      .cmp_valid                 (cmp_valid),
      .cmp_src                   (cmp_src),
      .cmp_op                    (cmp_op),
      .cmp_status                (cmp_status),
      .illegal_op                (illegal_op),
      .q_count                   (q_count),
      .busy                      (busy)
   );

   assign en_v = {en_erase_page, en_read, en_write_page};

   always @(negedge clk) begin
      if ($countones(en_v) > 1) onehot_bad <= onehot_bad + 1;
      if (cmp_valid) cmp_q.push_back({cmp_src, cmp_op, cmp_status});
      if (req0_ready) acc_q.push_back(1'b0);
      if (req1_ready) acc_q.push_back(1'b1);
      if (en_v != 3'b000) begin
         if (seen_en && low_run > 0 && low_run < min_gap) min_gap <= low_run;
         seen_en <= 1'b1;
         low_run <= 0;
      end else begin
         low_run <= low_run + 1;
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: observed still running, expected finished");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic submit(input logic src, input logic [1:0] op, input logic [23:0] row);
      if (src) begin req1_valid = 1; req1_op = op; req1_row = row; end
      else     begin req0_valid = 1; req0_op = op; req0_row = row; end
      #1;
      chk("submit_ready", src ? req1_ready : req0_ready, 1);
      tick();
      req0_valid = 0;
      req1_valid = 0;
   endtask

   task automatic wait_en(input int which, input string tag);
      int n = 0;
      while (en_v[which] !== 1'b1 && n < 300) begin tick(); n++; end
      chk(tag, n < 300, 1);
   endtask

   task automatic serve(input int which, input int delay);
      wait_en(which, "serve_en_rise");
      repeat (delay) tick();
      case (which)
         0:       end_write_page = 1;
         1:       end_read = 1;
         default: end_erase_page = 1;
      endcase
      tick();
      end_write_page = 0;
      end_read = 0;
      end_erase_page = 0;
      tick();
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy !== 1'b0 && n < 500) begin tick(); n++; end
      chk(tag, busy, 0);
   endtask

   initial begin
      int n, nacc;
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_en", en_v, 0);
      chk("rst_addr", write_addr_row | read_addr_row | erase_addr_row, 0);
      chk("rst_cmp", {cmp_valid, cmp_src, cmp_op, cmp_status}, 0);
      chk("rst_qcount", q_count, 0);
      chk("rst_busy_illegal", {busy, illegal_op}, 0);
      rst = 1;
      tick();

      // Single write, end pulse 50 cycles after enable rises
      cmp_q.delete();
      submit(0, W, 24'h000140);
      chk("t1_q_after_accept", q_count, 1);
      chk("t1_en_low_e0", en_v, 0);
      tick();
      chk("t1_issue_addr", write_addr_row, 24'h000140);
      chk("t1_issue_en_low", en_v, 0);
      tick();
      chk("t1_en_after_2_edges", en_v, 3'b001);
      repeat (49) tick();
      chk("t1_en_held", en_write_page, 1);
      chk("t1_addr_held", write_addr_row, 24'h000140);
      end_write_page = 1;
      tick();
      end_write_page = 0;
      chk("t1_cmp", {cmp_valid, cmp_src, cmp_op, cmp_status}, 6'b1_0_00_00);
      chk("t1_done_en_low", en_v, 0);
      chk("t1_done_addr", write_addr_row, 24'h000140);
      tick();
      chk("t1_gap_cmp_low", cmp_valid, 0);
      chk("t1_gap_addr_zero", write_addr_row, 0);
      wait_idle("t1_idle");
      chk("t1_cmp_once", cmp_q.size(), 1);

      // Both requesters reading continuously; req0 was granted last, so req1 goes first
      cmp_q.delete();
      acc_q.delete();
      req0_valid = 1; req0_op = R; req0_row = 24'h000100;
      req1_valid = 1; req1_op = R; req1_row = 24'h000200;
      serve(1, 3);
      serve(1, 3);
      req0_valid = 0;
      req1_valid = 0;
      nacc = acc_q.size();
      chk("t2_enough_accepts", nacc >= 4, 1);
      for (int i = 0; i < 12 && cmp_q.size() < nacc; i++) serve(1, 3);
      chk("t2_cmp_count", cmp_q.size(), nacc);
      for (int i = 0; i < nacc; i++) begin
         chk("t2_accept_order", acc_q[i], (i % 2 == 0) ? 1 : 0);
         chk("t2_cmp_entry", cmp_q[i], {acc_q[i], R, 2'd0});
      end
      chk("t2_min_gap", min_gap, 7);
      wait_idle("t2_idle");

      // Stall an erase, fill the queue, flush it
      cmp_q.delete();
      req0_valid = 1; req0_op = E; req0_row = 24'h000300;
      repeat (8) tick();
      req1_valid = 1; req1_op = E; req1_row = 24'h000310;
      #1;
      chk("t3_full_count", q_count, 4);
      chk("t3_both_ready_low", {req0_ready, req1_ready}, 0);
      chk("t3_inflight_en", en_erase_page, 1);
      tick();
      req0_valid = 0;
      req1_valid = 0;
      flush = 1;
      tick();
      flush = 0;
      chk("t3_flushed", q_count, 0);
      chk("t3_en_survives_flush", en_erase_page, 1);
      serve(2, 5);
      wait_idle("t3_idle");
      chk("t3_cmp_count", cmp_q.size(), 1);
      chk("t3_cmp_entry", cmp_q[0], {1'b0, E, 2'd0});

      // Timeout after 100 cycles of enable, then end pulse on the timeout cycle
      submit(1, R, 24'h000400);
      wait_en(1, "t4_en_rise");
      n = 0;
      while (en_read === 1'b1 && n < 200) begin tick(); n++; end
      chk("t4_en_high_cycles", n, 100);
      chk("t4_cmp", {cmp_valid, cmp_src, cmp_op, cmp_status}, 6'b1_1_01_01);
      chk("t4_addr", read_addr_row, 24'h000400);
      wait_idle("t4_idle_a");
      submit(0, R, 24'h000410);
      wait_en(1, "t4b_en_rise");
      repeat (99) tick();
      chk("t4b_en_last_cycle", en_read, 1);
      end_read = 1;
      tick();
      end_read = 0;
      chk("t4b_cmp_end_wins", {cmp_valid, cmp_src, cmp_op, cmp_status}, 6'b1_0_01_00);
      wait_idle("t4_idle_b");

      // No-response during a write with an erase queued behind it
      cmp_q.delete();
      submit(0, W, 24'h000500);
      submit(1, E, 24'h000600);
      wait_en(0, "t5_en_rise");
      noresp = 1;
      tick();
      noresp = 0;
      chk("t5_cmp_noresp", {cmp_valid, cmp_src, cmp_op, cmp_status}, 6'b1_0_00_10);
      chk("t5_en_low", en_v, 0);
      n = 0;
      while (en_erase_page !== 1'b1 && n < 50) begin tick(); n++; end
      chk("t5_next_issue_edges", n, 7);
      chk("t5_next_addr", erase_addr_row, 24'h000600);
      serve(2, 2);
      chk("t5_cmp_count", cmp_q.size(), 2);
      chk("t5_cmp_second", cmp_q[1], {1'b1, E, 2'd0});
      wait_idle("t5_idle");

      // Illegal op: accepted, flagged, never queued
      req0_valid = 1; req0_op = ILL; req0_row = 24'h000900;
      #1;
      chk("t5_illegal_ready", req0_ready, 1);
      tick();
      req0_valid = 0;
      chk("t5_illegal_flag", illegal_op, 1);
      chk("t5_illegal_not_queued", q_count, 0);
      chk("t5_illegal_not_busy", busy, 0);

      // Asynchronous reset while erasing with a write queued
      submit(1, E, 24'h000700);
      submit(0, W, 24'h000710);
      wait_en(2, "t6_en_rise");
      chk("t6_queued", q_count, 1);
      cmp_q.delete();
      #2;
      rst = 0;
      #1;
      chk("t6_en_dropped", en_v, 0);
      chk("t6_addr_zero", erase_addr_row, 0);
      chk("t6_q_cleared", q_count, 0);
      chk("t6_flags_cleared", {busy, illegal_op}, 0);
      repeat (2) @(posedge clk);
      tick();
      rst = 1;
      chk("t6_no_cmp", cmp_q.size(), 0);
      req0_valid = 1; req0_op = W; req0_row = 24'h000800;
      req1_valid = 1; req1_op = W; req1_row = 24'h000810;
      #1;
      chk("t6_rr_reset_req0", {req0_ready, req1_ready}, 2'b10);
      tick();
      chk("t6_rr_then_req1", {req0_ready, req1_ready}, 2'b01);
      tick();
      req0_valid = 0;
      req1_valid = 0;
      serve(0, 4);
      serve(0, 4);
      chk("t6_cmp_count", cmp_q.size(), 2);
      chk("t6_cmp_first", cmp_q[0], {1'b0, W, 2'd0});
      chk("t6_cmp_second", cmp_q[1], {1'b1, W, 2'd0});
      wait_idle("t6_idle");

      chk("onehot_enables", onehot_bad, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
